// File: rtl/sap_ctrl_pkg.sv
// Shared constants and control-word layout for the 8-bit bus machine sequencer.
package sap_ctrl_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;

   typedef struct packed {
      logic pc_out;
      logic pc_inc;
      logic pc_jump;
      logic mar_in;
      logic ram_out;
      logic ram_in;
      logic ir_in;
      logic ir_out;
      logic a_load;
      logic a_out;
      logic b_load;
      logic alu_out;
      logic alu_sub;
      logic out_load;
   } ctrl_word_t;

endpackage

// File: rtl/micro_decode.sv
// Combinational microcode: (step, opcode, registered flags) -> control word.
module micro_decode
   import sap_ctrl_pkg::*;
(
   input  logic [2:0] step,
   input  logic [3:0] opcode,
   input  logic       flag_c,
   input  logic       flag_z,
   output ctrl_word_t cw,
   output logic       last_step,
   output logic       flag_ld,
   output logic       halt_req
);

   always_comb begin
      cw        = '0;
      last_step = 1'b0;
      flag_ld   = 1'b0;
      halt_req  = 1'b0;
      // Fetch steps ignore opcode entirely; it is not valid until T2.
      case (step)
         T0: begin
            cw.pc_out = 1'b1;
            cw.mar_in = 1'b1;
         end
         T1: begin
            cw.ram_out = 1'b1;
            cw.ir_in   = 1'b1;
            cw.pc_inc  = 1'b1;
         end
         T2: begin
            last_step = 1'b1;
            case (opcode)
               OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                  cw.ir_out = 1'b1;
                  cw.mar_in = 1'b1;
                  last_step = 1'b0;
               end
               OP_LDI: begin
                  cw.ir_out = 1'b1;
                  cw.a_load = 1'b1;
               end
               OP_JMP: begin
                  cw.ir_out  = 1'b1;
                  cw.pc_jump = 1'b1;
               end
               OP_JC: begin
                  cw.ir_out  = flag_c;
                  cw.pc_jump = flag_c;
               end
               OP_JZ: begin
                  cw.ir_out  = flag_z;
                  cw.pc_jump = flag_z;
               end
               OP_OUT: begin
                  cw.a_out    = 1'b1;
                  cw.out_load = 1'b1;
               end
               OP_HLT:  halt_req = 1'b1;
               default: ;
            endcase
         end
         T3: begin
            last_step = 1'b1;
            case (opcode)
               OP_LDA: begin
                  cw.ram_out = 1'b1;
                  cw.a_load  = 1'b1;
               end
               OP_STA: begin
                  cw.a_out  = 1'b1;
                  cw.ram_in = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  cw.ram_out = 1'b1;
                  cw.b_load  = 1'b1;
                  last_step  = 1'b0;
               end
               default: ;
            endcase
         end
         T4: begin
            last_step = 1'b1;
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               cw.alu_out = 1'b1;
               cw.a_load  = 1'b1;
               cw.alu_sub = (opcode == OP_SUB);
               flag_ld    = 1'b1;
            end
         end
         default: last_step = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// T-state counter, halt latch and C/Z flag register around the microcode decoder.
module control_sequencer
   import sap_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       cf,
   input  logic       zf,
   output logic       pc_out,
   output logic       pc_inc,
   output logic       pc_jump,
   output logic       mar_in,
   output logic       ram_out,
   output logic       ram_in,
   output logic       ir_in,
   output logic       ir_out,
   output logic       a_load,
   output logic       a_out,
   output logic       b_load,
   output logic       alu_out,
   output logic       alu_sub,
   output logic       out_load,
   output logic       halted,
   output logic [2:0] step
);

   logic [2:0] step_q;
   logic       halted_q, flag_c, flag_z;
   logic       last_step, flag_ld, halt_req;
   ctrl_word_t cw, cw_gated;

   micro_decode u_dec (
      .step      (step_q),
      .opcode    (opcode),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .cw        (cw),
      .last_step (last_step),
      .flag_ld   (flag_ld),
      .halt_req  (halt_req)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q   <= T0;
         halted_q <= 1'b0;
         flag_c   <= 1'b0;
         flag_z   <= 1'b0;
      end else if (!halted_q) begin
         if (halt_req) halted_q <= 1'b1;
         if (flag_ld) begin
            flag_c <= cf;
            flag_z <= zf;
         end
         step_q <= last_step ? T0 : step_q + 3'd1;
      end
   end

   // Reset gating is combinational so an async abort silences the bus at once.
   assign cw_gated = (rst || halted_q) ? '0 : cw;

   assign pc_out   = cw_gated.pc_out;
   assign pc_inc   = cw_gated.pc_inc;
   assign pc_jump  = cw_gated.pc_jump;
   assign mar_in   = cw_gated.mar_in;
   assign ram_out  = cw_gated.ram_out;
   assign ram_in   = cw_gated.ram_in;
   assign ir_in    = cw_gated.ir_in;
   assign ir_out   = cw_gated.ir_out;
   assign a_load   = cw_gated.a_load;
   assign a_out    = cw_gated.a_out;
   assign b_load   = cw_gated.b_load;
   assign alu_out  = cw_gated.alu_out;
   assign alu_sub  = cw_gated.alu_sub;
   assign out_load = cw_gated.out_load;
   assign halted   = halted_q;
   assign step     = step_q;

   a_bus_excl: assert property (@(posedge clk) disable iff (rst)
      $onehot0({pc_out, ram_out, ir_out, a_out, alu_out}));

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized check of control_sequencer against a per-instruction microprogram model.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] opcode;
   logic       cf, zf;
   logic       pc_out, pc_inc, pc_jump, mar_in, ram_out, ram_in, ir_in, ir_out;
   logic       a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;
   logic [2:0] step;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [13:0] PC_OUT  = 14'h2000, PC_INC  = 14'h1000, PC_JUMP = 14'h0800;
   localparam logic [13:0] MAR_IN  = 14'h0400, RAM_OUT = 14'h0200, RAM_IN  = 14'h0100;
   localparam logic [13:0] IR_IN   = 14'h0080, IR_OUT  = 14'h0040, A_LOAD  = 14'h0020;
   localparam logic [13:0] A_OUT   = 14'h0010, B_LOAD  = 14'h0008, ALU_OUT = 14'h0004;
   localparam logic [13:0] ALU_SUB = 14'h0002, OUT_LD  = 14'h0001;

   // Model state: registered flags as the spec defines them, plus the expected program.
   bit          mc, mz;
   logic [13:0] prog[$];

   control_sequencer dut (
      .clk(clk), .rst(rst), .opcode(opcode), .cf(cf), .zf(zf),
      .pc_out(pc_out), .pc_inc(pc_inc), .pc_jump(pc_jump), .mar_in(mar_in),
      .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
      .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
      .alu_sub(alu_sub), .out_load(out_load), .halted(halted), .step(step)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [13:0] obs();
      return {pc_out, pc_inc, pc_jump, mar_in, ram_out, ram_in, ir_in, ir_out,
              a_load, a_out, b_load, alu_out, alu_sub, out_load};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic build(input logic [3:0] op);
      prog = {PC_OUT | MAR_IN, RAM_OUT | IR_IN | PC_INC};
      case (op)
         4'h1: begin prog.push_back(IR_OUT | MAR_IN); prog.push_back(RAM_OUT | A_LOAD); end
         4'h2, 4'h3: begin
            prog.push_back(IR_OUT | MAR_IN);
            prog.push_back(RAM_OUT | B_LOAD);
            prog.push_back(ALU_OUT | A_LOAD | ((op == 4'h3) ? ALU_SUB : 14'h0));
         end
         4'h4: begin prog.push_back(IR_OUT | MAR_IN); prog.push_back(A_OUT | RAM_IN); end
         4'h5: prog.push_back(IR_OUT | A_LOAD);
         4'h6: prog.push_back(IR_OUT | PC_JUMP);
         4'h7: prog.push_back(mc ? (IR_OUT | PC_JUMP) : 14'h0);
         4'h8: prog.push_back(mz ? (IR_OUT | PC_JUMP) : 14'h0);
         4'hE: prog.push_back(A_OUT | OUT_LD);
         default: prog.push_back(14'h0);
      endcase
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_step"}, step, 0);
      chk({tag, "_halt"}, halted, 0);
      chk({tag, "_cw"}, obs(), 0);
   endtask

   // Entered and left 1 time unit after a rising edge; abort_at injects an async reset.
   task automatic run_instr(input logic [3:0] op, input bit force_f = 0, input bit fcf = 0,
                            input bit fzf = 0, input int abort_at = -1);
      build(op);
      for (int k = 0; k < prog.size(); k++) begin
         opcode = (k < 2) ? 4'($urandom) : op;
         cf = (force_f && k == 4) ? fcf : 1'($urandom);
         zf = (force_f && k == 4) ? fzf : 1'($urandom);
         @(negedge clk);
         chk($sformatf("op%0h_t%0d_step", op, k), step, k);
         chk($sformatf("op%0h_t%0d_cw", op, k), obs(), prog[k]);
         chk($sformatf("op%0h_t%0d_halt", op, k), halted, 0);
         if (k == abort_at) begin
            #2 rst = 1'b1;
            #1 chk_reset("abort");
            @(posedge clk);
            #1 rst = 1'b0;
            mc = 0; mz = 0;
            return;
         end
         if ((op == 4'h2 || op == 4'h3) && k == 4) begin mc = cf; mz = zf; end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; opcode = '0; cf = 1'b0; zf = 1'b0;
      mc = 0; mz = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset("por");
      @(posedge clk);
      #1 rst = 1'b0;

      run_instr(4'h5);
      run_instr(4'hE);
      run_instr(4'h2, 1, 1, 0);
      run_instr(4'h7);
      run_instr(4'h8);
      run_instr(4'h3, 1, 0, 1);
      run_instr(4'h8);
      run_instr(4'h7);

      // Flag hold: non-ALU instructions with random cf/zf, then re-test jumps.
      repeat (20) begin
         case ($urandom_range(0, 2))
            0: run_instr(4'h1);
            1: run_instr(4'h4);
            default: run_instr(4'hE);
         endcase
         run_instr(4'h7);
         run_instr(4'h8);
      end

      repeat (150) run_instr(4'($urandom_range(0, 14)));

      run_instr(4'hF);
      repeat (20) begin
         opcode = 4'($urandom); cf = 1'($urandom); zf = 1'($urandom);
         @(negedge clk);
         chk("hlt_halt", halted, 1);
         chk("hlt_step", step, 0);
         chk("hlt_cw", obs(), 0);
      end
      rst = 1'b1;
      #1 chk_reset("hlt_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      mc = 0; mz = 0;
      run_instr(4'h5);

      run_instr(4'h2, 1, 1, 1);
      run_instr(4'h2, 0, 0, 0, 3);
      run_instr(4'h0);
      run_instr(4'h7);
      run_instr(4'h8);
      run_instr(4'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
